// File: rtl/bfm_apb_slave_if.sv
// APB bus bundle for bfm_apb_slave: initiator signals, slave responses and
// the slave's transfer counters / protocol-violation flag.
`timescale 1ns/1ps

interface bfm_apb_slave_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  waits;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [15:0] err_count;
  logic        prot_err;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, waits,
    input  prdata, pready, pslverr, wr_count, rd_count, err_count, prot_err
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, waits,
    output prdata, pready, pslverr, wr_count, rd_count, err_count, prot_err
  );
endinterface

// File: rtl/bfm_apb_slave.sv
// APB slave model: word memory with programmable wait states, error response
// for misaligned/out-of-range addresses, transfer counters and protocol checker.
`timescale 1ns/1ps

module bfm_apb_slave #(
  parameter int AWORD = 8,
  parameter int TPD   = 1
) (
  input logic            i_pclk,
  input logic            i_preset,
  bfm_apb_slave_if.slave bus
);
  localparam int DEPTH = 1 << AWORD;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_wait_cnt, w_wait_cnt_nxt;
  logic [AWORD-1:0] r_word;
  logic             r_write;
  logic             r_err;
  logic [31:0]      r_wdata;
  logic             r_prot_err;
  logic [15:0]      r_wr_count, r_rd_count, r_err_count;
  logic [31:0]      r_mem [DEPTH];

  logic w_setup, w_access, w_addr_err;
  logic w_capture, w_complete, w_prot;

  // Outputs are zero-delay here; TPD only has meaning for the delayed sim variant.
  if (TPD < 0) begin : g_tpd_invalid
  end

  assign w_setup    = bus.psel & ~bus.penable;
  assign w_access   = bus.psel &  bus.penable;
  assign w_addr_err = (bus.paddr[1:0] != 2'b00) || ((bus.paddr >> (AWORD + 2)) != 32'd0);

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_capture      = 1'b0;
    w_complete     = 1'b0;
    w_prot         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_capture      = 1'b1;
          w_wait_cnt_nxt = bus.waits;
          w_state_nxt    = (bus.waits == 4'd0) ? S_READY : S_WAIT;
        end else if (w_access) begin
          w_prot = 1'b1;
        end
      end
      S_WAIT: begin
        if (!w_access) begin
          w_prot         = 1'b1;
          w_wait_cnt_nxt = 4'd0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
          if (r_wait_cnt == 4'd1) w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        w_state_nxt = S_IDLE;
        if (w_access) w_complete = 1'b1;
        else          w_prot     = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_word      <= '0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_wdata     <= 32'd0;
      r_prot_err  <= 1'b0;
      r_wr_count  <= 16'd0;
      r_rd_count  <= 16'd0;
      r_err_count <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_capture) begin
        r_word  <= bus.paddr[AWORD+1:2];
        r_write <= bus.pwrite;
        r_wdata <= bus.pwdata;
        r_err   <= w_addr_err;
      end
      if (w_prot) r_prot_err <= 1'b1;
      // Counters saturate rather than wrap.
      if (w_complete) begin
        if (r_err) begin
          if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        end else if (r_write) begin
          if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
        end else begin
          if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
        end
      end
    end
  end

  // NOTE: the memory is reset word by word because reset must read back as all zeros.
  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (w_complete && r_write && !r_err) begin
      r_mem[r_word] <= r_wdata;
    end
  end

  assign bus.pready    = (r_state == S_READY);
  assign bus.pslverr   = (r_state == S_READY) && r_err;
  assign bus.prdata    = (r_state == S_READY && !r_err && !r_write) ? r_mem[r_word] : 32'd0;
  assign bus.wr_count  = r_wr_count;
  assign bus.rd_count  = r_rd_count;
  assign bus.err_count = r_err_count;
  assign bus.prot_err  = r_prot_err;
endmodule

// File: doc/bfm_apb_slave.md
BFM_APB_SLAVE -- requirements
Module: bfm_apb_slave

Interface
REQ-001 Parameter AWORD, default 8: log2 of memory depth in 32-bit words (default 256 words).
REQ-002 Parameter TPD, default 1: output delay in ns on all registered outputs (simulation only).
REQ-003 PCLK  in  1  sole clock; all state changes on rising edge.
REQ-004 PRESET  in  1  reset, asynchronous, active-high.
REQ-005 PSEL  in  1  select from the APB initiator.
REQ-006 PENABLE  in  1  access phase indicator.
REQ-007 PWRITE  in  1  1=write, 0=read.
REQ-008 PADDR  in  32  byte address.
REQ-009 PWDATA  in  32  write data.
REQ-010 WAITS  in  4  wait states inserted per transfer, sampled in the setup cycle.
REQ-011 PRDATA  out  32  read data.
REQ-012 PREADY  out  1  transfer completion.
REQ-013 PSLVERR  out  1  transfer error, valid only while PREADY=1.
REQ-014 WR_COUNT, RD_COUNT, ERR_COUNT  out  16 each  completed-transfer counters.
REQ-015 PROT_ERR  out  1  sticky initiator protocol-violation flag.

Function
REQ-016 States: IDLE, WAIT, READY; single transfer outstanding at a time.
REQ-017 IDLE: on PSEL=1 and PENABLE=0 (setup cycle), capture PADDR, PWRITE, PWDATA and the error flag; if WAITS=0 go READY, else load wait counter with WAITS and go WAIT.
REQ-018 Error flag = 1 when PADDR[1:0]!=0 or PADDR[31:AWORD+2]!=0.
REQ-019 WAIT: requires PSEL=1 and PENABLE=1; if counter=1 go READY, else decrement; WAITS=N yields exactly N access cycles with PREADY=0.
REQ-020 READY: PREADY=1, PSLVERR=error flag; on PSEL=1 and PENABLE=1 the transfer completes at that edge; go IDLE.
REQ-021 Completed write, no error: mem[PADDR[AWORD+1:2]] <= captured PWDATA at completion edge; errored write leaves memory untouched.
REQ-022 PRDATA = mem[captured word address] in READY for a non-errored read; 0 in every other state and case.
REQ-023 PREADY=0 and PSLVERR=0 in IDLE and WAIT; PREADY deasserts the cycle after completion.
REQ-024 Back-to-back: setup cycle presented in the cycle after completion is accepted from IDLE with no extra idle cycle required.
REQ-025 Protocol violation (PSEL or PENABLE low in WAIT/READY, or PENABLE=1 with PSEL=1 in IDLE): set PROT_ERR, abort to IDLE, no memory write, no counter change.
REQ-026 Counters increment at completion edge: ERR_COUNT for errored transfers, else WR_COUNT or RD_COUNT; each saturates at 0xFFFF.
REQ-027 PREADY reaches 1 at minimum one cycle after setup (zero-wait access), never in the setup cycle.

Reset
REQ-028 PRESET=1 immediately forces IDLE, PREADY=0, PSLVERR=0, PRDATA=0, all counters 0, PROT_ERR=0, wait counter 0, every memory word 0.
REQ-029 Reset asserted mid-transfer aborts it with no memory write; first setup cycle after PRESET deasserts is accepted normally.

Verification
REQ-030 WAITS=0: write 0x12345678 to 0x10, read 0x10 -> PREADY high in first access cycle each time, PRDATA=0x12345678, WR_COUNT=1, RD_COUNT=1.
REQ-031 WAITS=3: read 0x0 after reset -> three access cycles PREADY=0, fourth PREADY=1, PRDATA=0.
REQ-032 Write to 0x400 (AWORD=8) and to 0x2 -> PSLVERR=1 with PREADY, memory unchanged, ERR_COUNT=2, PRDATA=0.
REQ-033 PSEL dropped during WAIT (WAITS=2) write -> PROT_ERR=1, target word unchanged, counters unchanged; next valid transfer completes normally.
REQ-034 PRESET pulsed during WAIT of a write -> memory word stays 0, all outputs at reset values; 65536 reads -> RD_COUNT holds 0xFFFF.
